// File: rtl/q_route_pkg.sv
// Shared definitions for the Q-routing pipeline: word width, memory map bases
// and the scan FSM state encoding.
package q_route_pkg;

    localparam int          WORD_WIDTH   = 16;
    localparam logic [15:0] QTABLE_BASE  = 16'h048;
    localparam logic [15:0] NBR_ID_BASE  = 16'h008;
    localparam logic [15:0] CLUSTER_BASE = 16'h148;
    localparam logic [15:0] HOP_BASE     = 16'h1C8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } q_state_e;

    // Byte address of 16-bit word idx in a table starting at base (wraps mod 2^16).
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
        return base + {idx[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/q_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), synchronous active-low reset.
module q_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        nreset,
    output logic [15:0] lfsr
);

    always_ff @(posedge clock) begin
        if (!nreset)
            lfsr <= SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

endmodule

// File: rtl/q_besthop_select.sv
// Scans the neighbour Q-table for the highest Q-value and fetches that neighbour's node ID.
// Optional epsilon-greedy exploration is compiled in with Q_EXPLORE_EN.
module q_besthop_select
    import q_route_pkg::*;
#(
    parameter int MAX_NEIGHBORS = 32,
    parameter int EPSILON       = 2
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    input  logic [15:0] neighbor_count,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic [15:0] action,
    output logic [15:0] besthop,
    output logic [15:0] best_q,
    output logic        explored,
    output logic        done
);

    localparam logic [15:0] MAX_N = 16'(MAX_NEIGHBORS);

    if (EPSILON < 0) begin : g_bad_epsilon
        $error("EPSILON must be non-negative");
    end

    q_state_e    state, state_nxt;
    logic [15:0] idx;
    logic [15:0] cnt_m;
    logic [15:0] m_eff;
    logic        scan_last;
    logic        take;
    logic [15:0] greedy_win;
    logic [15:0] final_win;
    logic [15:0] final_q;
    logic        explore_hit;
    logic [15:0] pick;
    logic [15:0] pick_q;

    assign m_eff      = (neighbor_count > MAX_N) ? MAX_N : neighbor_count;
    assign scan_last  = (idx == cnt_m - 16'd1);
    // Strict compare so ties keep the lower index; entry 0 always seeds the best.
    assign take       = (idx == 16'd0) || (data_in > best_q);
    assign greedy_win = take ? idx : action;
    assign final_win  = explore_hit ? pick : greedy_win;
    assign final_q    = explore_hit ? pick_q : (take ? data_in : best_q);

`ifdef Q_EXPLORE_EN
    logic [15:0] lfsr;
    logic [15:0] qcap [32];

    q_lfsr16 u_lfsr (
        .clock  (clock),
        .nreset (nreset),
        .lfsr   (lfsr)
    );

    assign pick        = {11'd0, lfsr[8:4]};
    assign explore_hit = (int'(lfsr[3:0]) < EPSILON) && (pick < cnt_m);
    // The picked entry may be the one on the bus right now, not yet captured.
    assign pick_q      = (pick == idx) ? data_in : qcap[lfsr[8:4]];

    always_ff @(posedge clock) begin
        if (state == SCAN && idx[15:5] == 11'd0)
            qcap[idx[4:0]] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (!nreset)
            explored <= 1'b0;
        else if (state == IDLE && start)
            explored <= 1'b0;
        else if (state == SCAN && scan_last)
            explored <= explore_hit;
    end
`else
    assign pick        = 16'd0;
    assign pick_q      = 16'd0;
    assign explore_hit = 1'b0;
    assign explored    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!nreset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (m_eff == 16'd0) ? DONE : SCAN;
            SCAN:    if (scan_last) state_nxt = FETCH;
            FETCH:   state_nxt = DONE;
            // Exit only once done has been seen, so an empty-table result still pulses done.
            DONE:    if (!start && done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            idx     <= 16'd0;
            cnt_m   <= 16'd0;
            address <= 16'd0;
            action  <= 16'd0;
            besthop <= 16'd0;
            best_q  <= 16'd0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= 16'd0;
                        cnt_m  <= m_eff;
                        best_q <= 16'd0;
                        if (m_eff == 16'd0) begin
                            action  <= 16'hFFFF;
                            besthop <= 16'hFFFF;
                        end else begin
                            action  <= 16'd0;
                            address <= QTABLE_BASE;
                        end
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        action  <= final_win;
                        best_q  <= final_q;
                        address <= word_addr(NBR_ID_BASE, final_win);
                    end else begin
                        if (take) begin
                            action <= idx;
                            best_q <= data_in;
                        end
                        idx     <= idx + 16'd1;
                        address <= address + 16'd2;
                    end
                end
                FETCH: begin
                    besthop <= data_in;
                    done    <= 1'b1;
                end
                DONE: begin
                    done <= done ? start : 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
